// File: rtl/regfile_sb.sv
// Integer register file with a pending-write scoreboard: bypassed decode reads,
// per-operand busy flags for RAW stalls, a registered debug read and flush handling.
module regfile_sb #(
    parameter int XLEN    = 32,
    parameter int REG_NUM = 32,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_reg_en,
    input  logic [ADDR_W-1:0] wb_reg_addr,
    input  logic [XLEN-1:0]   wb_reg_wdata,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_rd_addr,
    input  logic              flush,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]   rs1_rdata,
    output logic [XLEN-1:0]   rs2_rdata,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              pending_any,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [XLEN-1:0]   dbg_rdata
);

    logic                wb_active;
    logic                issue_active;
    logic [XLEN-1:0]     reg_q [REG_NUM];
    logic [REG_NUM-1:0]  pending_reg;
    logic [REG_NUM-1:0]  pending_next;
    logic [XLEN-1:0]     dbg_rdata_reg;
    logic [ADDR_W-1:0]   rd_addr [2];
    logic [XLEN-1:0]     rd_data [2];
    logic                rd_busy [2];

    assign wb_active    = wb_reg_en && (wb_reg_addr != '0);
    assign issue_active = issue_en && (issue_rd_addr != '0);

    // x0 has no storage; its read value is tied to zero in the mux array.
    assign reg_q[0] = '0;

    // Flop-based storage: every register must clear on reset, which rules out block RAM.
    generate
        for (genvar gi = 1; gi < REG_NUM; gi++) begin : g_reg
            logic [XLEN-1:0] q_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    q_reg <= '0;
                end else if (wb_active && (wb_reg_addr == ADDR_W'(gi))) begin
                    q_reg <= wb_reg_wdata;
                end
            end

            assign reg_q[gi] = q_reg;
        end
    endgenerate

    // Issue wins over a same-cycle writeback clear because the issued instruction is younger.
    always_comb begin
        pending_next = pending_reg;
        if (flush) begin
            pending_next = '0;
        end else begin
            if (wb_active) begin
                pending_next[wb_reg_addr] = 1'b0;
            end
            if (issue_active) begin
                pending_next[issue_rd_addr] = 1'b1;
            end
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    assign pending_any = |pending_reg;

    // Two identical decode ports: writeback data is forwarded and clears busy in the same cycle.
    assign rd_addr[0] = rs1_addr;
    assign rd_addr[1] = rs2_addr;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic wb_hit;

            assign wb_hit      = wb_active && (wb_reg_addr == rd_addr[gi]);
            assign rd_data[gi] = wb_hit ? wb_reg_wdata : reg_q[rd_addr[gi]];
            assign rd_busy[gi] = pending_reg[rd_addr[gi]] && !wb_hit;
        end
    endgenerate

    assign rs1_rdata = rd_data[0];
    assign rs2_rdata = rd_data[1];
    assign rs1_busy  = rd_busy[0];
    assign rs2_busy  = rd_busy[1];

    // Debug reads the stored array only, so a same-cycle write shows up one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_rdata_reg <= '0;
        end else begin
            dbg_rdata_reg <= reg_q[dbg_addr];
        end
    end

    assign dbg_rdata = dbg_rdata_reg;

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Integer register file with a pending-write scoreboard for the 5-stage RV32I core.
- Sink end of the result path: receives the final rd write (enable, address, data) that the ALU produces and the alu_mem/mem_wb registers carry to writeback.
- Serves decode with two bypassed read ports and per-operand busy flags, so decode can stall on unresolved RAW hazards.
- Also provides a debug read port and flush handling for branch/jump redirects.

Parameters:
- XLEN, 32, data width of each register
- REG_NUM, 32, number of architectural registers; x0 is hardwired to zero
- ADDR_W, 5, register address width; REG_NUM = 2^ADDR_W

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- wb_reg_en  input  1  writeback write enable
- wb_reg_addr  input  ADDR_W  writeback destination register
- wb_reg_wdata  input  XLEN  writeback data
- issue_en  input  1  decode issues an instruction that writes rd
- issue_rd_addr  input  ADDR_W  rd of the issued instruction
- flush  input  1  pipeline redirect; clears all pending marks
- rs1_addr  input  ADDR_W  decode source 1 address
- rs2_addr  input  ADDR_W  decode source 2 address
- rs1_rdata  output  XLEN  source 1 data (combinational)
- rs2_rdata  output  XLEN  source 2 data (combinational)
- rs1_busy  output  1  source 1 has an outstanding write
- rs2_busy  output  1  source 2 has an outstanding write
- pending_any  output  1  at least one pending bit is set
- dbg_addr  input  ADDR_W  debug read address
- dbg_rdata  output  XLEN  debug read data (registered)

Behaviour:
- State:
  - regs[1..REG_NUM-1], XLEN bits each.
  - pending[1..REG_NUM-1], 1 bit each.
  - dbg_rdata register.
  - x0 has no storage and no pending bit.
- Reset (rst=1 at edge): all regs, all pending bits and dbg_rdata go to 0. Reset overrides every other input in that cycle, including a write or issue in flight.
- Write:
  - At the edge, if wb_reg_en=1 and wb_reg_addr!=0, then regs[wb_reg_addr] <= wb_reg_wdata.
  - Writes to x0 are discarded.
  - A write to a register that is not pending is still performed.
- Read ports (rs1 and rs2, identical, 0-cycle latency):
  - Address 0 returns 0.
  - Otherwise, if wb_reg_en=1 and wb_reg_addr equals the read address, return wb_reg_wdata (write-through bypass).
  - Otherwise return regs[addr].
- Busy flags:
  - rsN_busy = pending[rsN_addr] AND NOT (wb_reg_en AND wb_reg_addr == rsN_addr).
  - Address 0 is never busy.
  - Busy is based on registered pending state; an issue in the same cycle does not raise busy until the next cycle.
- Pending update at the edge, in priority order, highest first:
  1. rst: clear all.
  2. flush: clear all pending bits. A simultaneous issue_en is dropped. A simultaneous wb write still updates regs.
  3. issue_en=1 and issue_rd_addr!=0: set pending[issue_rd_addr]. This wins over a same-cycle writeback clear to the same address, because the new instruction is younger.
  4. wb_reg_en=1 and wb_reg_addr!=0: clear pending[wb_reg_addr].
  - Set and clear to different addresses in the same cycle both take effect.
- pending_any: OR of all pending bits, driven from registered state.
- Debug port: dbg_rdata <= (dbg_addr==0) ? 0 : regs[dbg_addr] at each edge. Latency is 1 cycle, with no bypass, so it shows the pre-write value in a same-cycle write.
- Single outstanding write per register is the decode contract. Re-issuing to a pending rd just keeps the bit set; there is no counter.

Test Plan:
- Reset then read: rst held 2 cycles, then rs1_addr=5, rs2_addr=31 -> rs1_rdata=0, rs2_rdata=0, both busy=0, pending_any=0, dbg_rdata=0.
- Write and bypass: wb_reg_en=1, addr=3, wdata=0x1234_5678 with rs1_addr=3 -> rs1_rdata=0x12345678 in the same cycle; wb_reg_en=0 next cycle -> still 0x12345678; dbg_addr=3 -> dbg_rdata=0x12345678 one cycle later.
- x0 protection: wb_reg_en=1, addr=0, wdata=0xFFFF_FFFF; issue_en=1, issue_rd_addr=0 -> rs1_addr=0 reads 0, rs1_busy=0, pending_any stays 0.
- Scoreboard lifecycle: issue rd=7 at cycle N -> rs2_addr=7 gives busy=1 from N+1. At cycle N+3 wb addr=7, data=0xA5 -> busy=0 and rdata=0xA5 in N+3; pending[7] clear at N+4.
- Simultaneous issue and writeback to x9 (pending set): same edge -> pending[9] remains 1 next cycle and regs[9] is updated; issue x4 with wb x9 -> x4 set, x9 cleared.
- Flush and reset mid-operation:
  - Pending x2, x6; then flush=1 with issue_en=1, rd=8 -> pending_any=0 next cycle, x8 not busy.
  - rst=1 coinciding with wb addr=2, data=0x55 -> regs[2]=0 afterwards.
